// File: rtl/alu_writeback.sv
// Commit stage behind the 8-bit accumulator ALU: a 2-entry in-order buffer that retires
// instructions into the accumulator or the register-file write port and owns the flag register.
module alu_writeback #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_optype,
    input  logic [3:0]    in_op,
    input  logic          in_to_acc,
    input  logic [AW-1:0] in_dst,
    input  logic [DW-1:0] in_result,
    input  logic          in_z,
    input  logic          in_c,
    input  logic          in_n,
    input  logic          in_v,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic          rf_ack,
    output logic [DW-1:0] acc_q,
    output logic [3:0]    flags_q,
    output logic [15:0]   retire_cnt,
    output logic          busy
);

    typedef struct packed {
        logic          optype;
        logic [3:0]    op;
        logic          to_acc;
        logic [AW-1:0] dst;
        logic [DW-1:0] result;
        logic          z;
        logic          c;
        logic          n;
        logic          v;
    } entry_t;

    // Handshake: an instruction transfers at a rising edge where in_valid & in_ready.
    // in_ready depends only on the registered count, never on rf_ack.
    // The write port transfers at a rising edge where rf_we & rf_ack; address/data hold until then.

    entry_t     head;
    entry_t     tail;
    entry_t     in_entry;
    logic [1:0] count;
    logic       head_valid;
    logic       head_writes;
    logic       head_rf;
    logic       push;
    logic       commit;
    logic [3:0]    flags_next;
    logic [DW-1:0] acc_next;

    assign in_entry = {in_optype, in_op, in_to_acc, in_dst, in_result, in_z, in_c, in_n, in_v};

    assign head_valid  = (count != 2'd0);
    assign head_writes = head.optype | ((head.op >= 4'd2) && (head.op <= 4'd9));
    assign head_rf     = head_valid & head_writes & ~head.to_acc;
    assign commit      = head_valid & (~head_rf | rf_ack);

    assign in_ready = (count != 2'd2);
    assign push     = in_valid & in_ready;
    assign busy     = head_valid;
    assign rf_we    = head_rf;
    assign rf_waddr = head.dst;
    assign rf_wdata = head.result;

    // Flag layout is {z,c,n,v}; non-ALU moves and unlisted opcodes leave flags alone.
    always_comb begin
        flags_next = flags_q;
        acc_next   = acc_q;
        if (!head.optype) begin
            case (head.op)
                4'd2, 4'd3:
                    flags_next = {head.result == '0, head.c, head.result[DW-1], head.v};
                4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                    flags_next = {head.result == '0, flags_q[2], head.result[DW-1], flags_q[0]};
                4'd10:
                    flags_next = {head.z, flags_q[2], head.n, flags_q[0]};
                default: ;
            endcase
        end
        if (head_writes && head.to_acc) begin
            acc_next = head.result;
        end
    end

    // Head lives in a fixed slot so the write port comes straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= 2'd0;
            acc_q      <= '0;
            flags_q    <= 4'd0;
            retire_cnt <= 16'd0;
        end else begin
            if (push && commit) begin
                if (count == 2'd2) begin
                    head <= tail;
                    tail <= in_entry;
                end else begin
                    head <= in_entry;
                end
            end else if (commit) begin
                head  <= tail;
                count <= count - 2'd1;
            end else if (push) begin
                if (count == 2'd0) begin
                    head <= in_entry;
                end else begin
                    tail <= in_entry;
                end
                count <= count + 2'd1;
            end
            if (commit) begin
                acc_q      <= acc_next;
                flags_q    <= flags_next;
                retire_cnt <= retire_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed test-plan steps followed by random traffic, all checked
// against a transaction-level model of the commit rules.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_optype;
    logic [3:0]  in_op;
    logic        in_to_acc;
    logic [3:0]  in_dst;
    logic [7:0]  in_result;
    logic        in_z, in_c, in_n, in_v;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        rf_ack;
    logic [7:0]  acc_q;
    logic [3:0]  flags_q;
    logic [15:0] retire_cnt;
    logic        busy;

    alu_writeback #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_optype(in_optype), .in_op(in_op), .in_to_acc(in_to_acc), .in_dst(in_dst),
        .in_result(in_result), .in_z(in_z), .in_c(in_c), .in_n(in_n), .in_v(in_v),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
        .acc_q(acc_q), .flags_q(flags_q), .retire_cnt(retire_cnt), .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    typedef struct packed {
        logic       optype;
        logic [3:0] op;
        logic       to_acc;
        logic [3:0] dst;
        logic [7:0] result;
        logic       z, c, n, v;
    } ins_t;

    ins_t        mq[$];
    logic [11:0] exp_q[$];
    logic [7:0]  m_acc;
    logic [3:0]  m_flags;
    logic [15:0] m_ret;
    bit          last_acc;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes_data(input ins_t e);
        return e.optype || (e.op >= 4'd2 && e.op <= 4'd9);
    endfunction

    // Architectural effect of retiring one instruction.
    task automatic retire(input ins_t h);
        logic z, c, n, v;
        {z, c, n, v} = m_flags;
        if (!h.optype) begin
            if (h.op == 4'd2 || h.op == 4'd3) begin
                z = (h.result == 8'd0); n = h.result[7]; c = h.c; v = h.v;
            end else if (h.op >= 4'd4 && h.op <= 4'd9) begin
                z = (h.result == 8'd0); n = h.result[7];
            end else if (h.op == 4'd10) begin
                z = h.z; n = h.n;
            end
        end
        m_flags = {z, c, n, v};
        if (writes_data(h) && h.to_acc) m_acc = h.result;
        if (writes_data(h) && !h.to_acc) exp_q.push_back({h.dst, h.result});
        m_ret = m_ret + 16'd1;
    endtask

    // Check outputs against the model, advance the model with the current inputs, then clock.
    task automatic tick();
        bit   exp_we;
        bit   do_commit;
        ins_t cur;
        chk("in_ready", in_ready, mq.size() < 2);
        chk("busy", busy, mq.size() != 0);
        exp_we = (mq.size() != 0) && writes_data(mq[0]) && !mq[0].to_acc;
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_waddr", rf_waddr, mq[0].dst);
            chk("rf_wdata", rf_wdata, mq[0].result);
        end
        chk("acc_q", acc_q, m_acc);
        chk("flags_q", flags_q, m_flags);
        chk("retire_cnt", retire_cnt, m_ret);
        last_acc  = in_valid && (mq.size() < 2);
        do_commit = (mq.size() != 0) && (!exp_we || rf_ack);
        cur = {in_optype, in_op, in_to_acc, in_dst, in_result, in_z, in_c, in_n, in_v};
        if (do_commit) retire(mq.pop_front());
        if (last_acc) mq.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic optype, input logic [3:0] op, input logic to_acc,
                         input logic [3:0] dst, input logic [7:0] result,
                         input logic z, input logic c, input logic n, input logic v);
        in_valid = 1'b1; in_optype = optype; in_op = op; in_to_acc = to_acc; in_dst = dst;
        in_result = result; in_z = z; in_c = c; in_n = n; in_v = v;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        mq.delete();
        m_acc = 8'd0; m_flags = 4'd0; m_ret = 16'd0;
        chk("rst_acc", acc_q, 8'd0);
        chk("rst_flags", flags_q, 4'd0);
        chk("rst_retire", retire_cnt, 16'd0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_hold_rf_we", rf_we, 1'b0);
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard on the write port ----------------
    always @(negedge clk) begin
        if (rst_n && rf_we && rf_ack) begin
            if (exp_q.size() == 0) begin
                chk("rf_unexpected_write", {rf_waddr, rf_wdata}, 12'hFFF ^ {rf_waddr, rf_wdata});
            end else begin
                chk("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0; n_fail = 0;
        m_acc = 8'd0; m_flags = 4'd0; m_ret = 16'd0; last_acc = 0;
        rst_n = 1'b0; rf_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // ADD to acc, result 0, carry in
        drive(0, 4'd2, 1, 0, 8'h00, 0, 1, 0, 0); tick(); idle(); tick();
        chk("tp_add_acc", acc_q, 8'h00);
        chk("tp_add_flags", flags_q, 4'b1100);
        chk("tp_add_ret", retire_cnt, 16'd1);

        // AND, c retained
        drive(0, 4'd6, 1, 0, 8'hF0, 0, 0, 0, 0); tick(); idle(); tick();
        chk("tp_and_acc", acc_q, 8'hF0);
        chk("tp_and_flags", flags_q, 4'b0110);

        // CMP: no write, z/n from ALU
        drive(0, 4'd10, 1, 0, 8'h55, 0, 0, 1, 0); tick(); idle(); tick();
        chk("tp_cmp_acc", acc_q, 8'hF0);
        chk("tp_cmp_flags", flags_q, 4'b0110);
        chk("tp_cmp_ret", retire_cnt, 16'd3);

        // Unassigned opcode 1111: retires, nothing else
        drive(0, 4'd15, 0, 4'd7, 8'hAA, 1, 1, 1, 1); tick(); idle();
        chk("tp_op15_rf_we", rf_we, 1'b0);
        tick();
        chk("tp_op15_acc", acc_q, 8'hF0);
        chk("tp_op15_flags", flags_q, 4'b0110);
        chk("tp_op15_ret", retire_cnt, 16'd4);

        // Three RF writes with ack held low
        rf_ack = 1'b0;
        drive(1, 4'd0, 0, 4'd3, 8'h11, 0, 0, 0, 0); tick();
        drive(1, 4'd0, 0, 4'd4, 8'h22, 0, 0, 0, 0); tick();
        drive(1, 4'd0, 0, 4'd5, 8'h33, 0, 0, 0, 0);
        chk("stall_in_ready", in_ready, 1'b0);
        tick();
        chk("stall_no_accept", last_acc, 1'b0);
        chk("stall_waddr", rf_waddr, 4'd3);
        chk("stall_wdata", rf_wdata, 8'h11);
        tick();
        chk("stall_no_accept2", last_acc, 1'b0);
        rf_ack = 1'b1;
        tick();
        chk("stall_no_accept_ack", last_acc, 1'b0);
        tick();
        chk("stall_accept_after_ack", last_acc, 1'b1);
        idle(); tick(); tick();
        chk("stall_ret", retire_cnt, 16'd7);
        chk("stall_drained", exp_q.size(), 0);

        // Stalled RF write, younger acc ADD, then reset before ack
        rf_ack = 1'b0;
        drive(1, 4'd0, 0, 4'd9, 8'h77, 0, 0, 0, 0); tick();
        drive(0, 4'd2, 1, 0, 8'h05, 0, 1, 0, 1); tick();
        idle(); tick();
        chk("order_acc_held", acc_q, 8'hF0);
        reset_pulse();
        tick(); tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rf_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
                drive($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 1'($urandom),
                      4'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                idle();
            end
            tick();
        end
        idle(); rf_ack = 1'b1;
        repeat (4) tick();
        chk("final_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Commit stage directly downstream of the 8-bit accumulator ALU. It accepts one executed instruction per cycle (result plus z/c/n/v) over a valid/ready handshake and buffers up to two in a FIFO. It commits them in order: either into the architectural accumulator or to the register-file write port, which can stall. It owns the architectural flag register and applies the per-opcode flag-update rules.

## Interface
- DW, 8, data width (accumulator, result, register-file data)
- AW, 4, register-file address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  buffer can accept; transfer when in_valid & in_ready at rising edge
- in_optype  in  1  0 = ALU op, 1 = non-ALU move/load (result passed through)
- in_op  in  4  ALU opcode
- in_to_acc  in  1  1 = destination is accumulator, 0 = register file
- in_dst  in  AW  register-file destination index
- in_result  in  DW  ALU/move result
- in_z, in_c, in_n, in_v  in  1 each  ALU flag outputs
- rf_we  out  1  register-file write request
- rf_waddr  out  AW  write address
- rf_wdata  out  DW  write data
- rf_ack  in  1  write accepted this cycle (meaningful only with rf_we)
- acc_q  out  DW  committed accumulator
- flags_q  out  4  committed flags {z,c,n,v}
- retire_cnt  out  16  committed-instruction counter, wraps 0xFFFF→0x0000
- busy  out  1  buffer non-empty

## Operation
- Buffer: 2-entry in-order FIFO, count 0..2. Each entry captures all in_* fields at acceptance.
- in_ready = (count != 2). It does not depend on same-cycle pop, so there is no combinational path from rf_ack.
- Head classification:
  - WRITE_ACC: in_to_acc = 1 and the op writes data.
  - WRITE_RF: in_to_acc = 0 and the op writes data.
  - NOWRITE: the op writes no data.
- Opcode rules for optype = 0:
  - 0010 ADD, 0011 SUB: write data. z = (result == 0), n = result[DW-1], c = in_c, v = in_v.
  - 0100–1001 (SHL, SHR, AND, OR, XOR, POPCNT): write data. z and n computed from the result; c and v retained.
  - 1010 CMP: NOWRITE. z = in_z, n = in_n; c and v retained.
  - Any other opcode: NOWRITE, no flag change. The entry still retires.
- optype = 1: writes data, never updates flags.
- Commit, one per cycle at most:
  - WRITE_ACC and NOWRITE heads commit in the cycle they are at head.
  - WRITE_RF heads commit only in a cycle where rf_ack = 1.
- At a commit edge the stage pops the head, applies acc_q and flags_q updates, and increments retire_cnt.
- rf_we = head valid and head is WRITE_RF. rf_waddr and rf_wdata come from the head entry and stay stable until ack.
- Push and pop in the same cycle are both honoured; count is unchanged.

## Timing
- Reset (rst_n low, asynchronous) clears the following, and the values hold while rst_n is low:
  - count = 0, entries invalid, so rf_we = 0 and busy = 0
  - acc_q = 0, flags_q = 0, retire_cnt = 0
  - in_ready = 1
- Latency: an instruction accepted at edge N into an empty buffer is at head after edge N.
  - Earliest commit is edge N+1: acc_q and flags_q are visible after N+1.
  - rf_we is high in cycle N→N+1.
- Throughput: 1 instruction/cycle with rf_ack held high or with accumulator targets.
- RF stall: rf_we held, address and data stable, while rf_ack = 0.
  - A younger accumulator-target entry must not commit before the stalled head.
  - Up to one more instruction is accepted; in_ready then drops.
- Reset asserted mid-stall discards all buffered entries; no partial commit occurs.
- All outputs are driven directly from flops or from head-entry flops.

## Test plan
- ADD, to_acc, result 0x00, in_c = 1, in_v = 0 → after one cycle acc_q = 0x00, flags_q = 4'b1100, retire_cnt = 1.
- Then AND, result 0xF0, in_c = 0 → acc_q = 0xF0, flags_q = 4'b0110 (c retained, n = 1).
- CMP with in_z = 0, in_n = 1, result 0x55 after the above → acc_q unchanged at 0xF0, flags_q = 4'b0110, retire_cnt increments.
- Three back-to-back RF writes (dst 3, 4, 5; data 0x11, 0x22, 0x33) with rf_ack low for 3 cycles:
  - rf_waddr = 3, rf_wdata = 0x11 held
  - in_ready = 0 once count = 2
  - the third instruction is accepted only after the first ack
  - writes occur in order 3, 4, 5 on ack cycles
- RF write stalled, followed by an accumulator-target ADD; pulse rst_n low before ack → acc_q = 0, flags_q = 0, retire_cnt = 0, rf_we = 0 immediately, and no write occurs.
- Opcode 1111 with optype = 0, result 0xAA → acc_q and flags_q unchanged, rf_we never asserted, retire_cnt += 1.
